// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
// Shares one DDR3 controller user port between a write requester (CSI capture)
// and a read requester (HDMI fetch). Traffic is held off until calibration
// completes. Bursts are fixed length. Reads win arbitration, but a starvation
// limit guarantees that a waiting writer is eventually served. Read commands
// in flight are counted, and read data is passed back in order.
module ddr_port_arbiter #(
  parameter int BURST_LEN       = 16,
  parameter int ADDR_STEP       = 8,
  parameter int MAX_OUTSTANDING = 32,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         init_calib_complete,
  // write requester
  input  logic         wr_req,
  input  logic [27:0]  wr_addr,
  output logic         wr_gnt,
  input  logic [127:0] wr_data,
  input  logic         wr_data_valid,
  output logic         wr_data_ready,
  output logic         wr_done,
  // read requester
  input  logic         rd_req,
  input  logic [27:0]  rd_addr,
  output logic         rd_gnt,
  output logic         rd_done,
  output logic [127:0] rd_data,
  output logic         rd_data_valid,
  // controller user port
  output logic         app_cmd_en,
  output logic [2:0]   app_cmd,
  output logic [27:0]  app_addr,
  input  logic         app_cmd_rdy,
  output logic         app_wren,
  output logic [127:0] app_data,
  input  logic         app_data_rdy,
  input  logic         app_rdata_valid,
  input  logic [127:0] app_rdata,
  output logic         err_underflow
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);
  localparam logic [27:0]      ADDR_INC  = 28'(ADDR_STEP);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RD   = 2'd3;

  logic [1:0]       state_reg;
  logic [27:0]      cur_addr_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic [STV_W-1:0] starve_cnt_reg;
  logic [OUT_W-1:0] outstanding_reg;
  logic             wr_gnt_reg;
  logic             rd_gnt_reg;
  logic             wr_done_reg;
  logic             rd_done_reg;
  logic             err_reg;
  logic             rd_data_valid_reg;
  logic [127:0]     rd_data_reg;
  logic [2:0]       last_cmd_reg;
  logic [27:0]      last_addr_reg;

  logic wr_fire;
  logic rd_fire;
  logic beat_fire;
  logic last_beat;
  logic force_wr;
  logic grant_rd;
  logic grant_wr;

  // A write beat needs the command slot, the data slot and a valid beat all at
  // once, because command and data are presented together.
  assign wr_fire   = (state_reg == ST_WR) && app_cmd_rdy && app_data_rdy && wr_data_valid;
  // A read command is held back while the return window is full.
  assign rd_fire   = (state_reg == ST_RD) && app_cmd_rdy && (outstanding_reg < OUT_MAX);
  assign beat_fire = wr_fire || rd_fire;
  assign last_beat = (beat_cnt_reg == LAST_BEAT);

  // A writer that has watched STARVE_LIMIT read grants in a row takes the next slot.
  assign force_wr = wr_req && (starve_cnt_reg == STV_MAX);
  assign grant_rd = (state_reg == ST_IDLE) && rd_req && !force_wr;
  assign grant_wr = (state_reg == ST_IDLE) && !grant_rd && wr_req;

  // The command bus shows the live beat when one fires; otherwise it repeats
  // the last command so the controller never sees spurious address changes.
  assign app_cmd_en    = beat_fire;
  assign app_wren      = wr_fire;
  assign wr_data_ready = wr_fire;
  assign app_cmd       = beat_fire ? (rd_fire ? CMD_READ : CMD_WRITE) : last_cmd_reg;
  assign app_addr      = beat_fire ? cur_addr_reg : last_addr_reg;
  assign app_data      = wr_data;

  assign wr_gnt        = wr_gnt_reg;
  assign rd_gnt        = rd_gnt_reg;
  assign wr_done       = wr_done_reg;
  assign rd_done       = rd_done_reg;
  assign rd_data       = rd_data_reg;
  assign rd_data_valid = rd_data_valid_reg;
  assign err_underflow = err_reg;

  // Burst sequencer: calibration wait, arbitration, beat counting and address walk.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= ST_INIT;
      cur_addr_reg <= '0;
      beat_cnt_reg <= '0;
      wr_gnt_reg   <= 1'b0;
      rd_gnt_reg   <= 1'b0;
      wr_done_reg  <= 1'b0;
      rd_done_reg  <= 1'b0;
    end else begin
      wr_gnt_reg  <= 1'b0;
      rd_gnt_reg  <= 1'b0;
      wr_done_reg <= 1'b0;
      rd_done_reg <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          if (init_calib_complete) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (grant_rd) begin
            state_reg    <= ST_RD;
            cur_addr_reg <= rd_addr;
            beat_cnt_reg <= '0;
            rd_gnt_reg   <= 1'b1;
          end else if (grant_wr) begin
            state_reg    <= ST_WR;
            cur_addr_reg <= wr_addr;
            beat_cnt_reg <= '0;
            wr_gnt_reg   <= 1'b1;
          end
        end
        default: begin
          if (beat_fire) begin
            cur_addr_reg <= cur_addr_reg + ADDR_INC;
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            if (last_beat) begin
              state_reg   <= ST_IDLE;
              wr_done_reg <= (state_reg == ST_WR);
              rd_done_reg <= (state_reg == ST_RD);
            end
          end
        end
      endcase
    end
  end

  // Starvation counter: counts read grants that bypassed a waiting writer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      starve_cnt_reg <= '0;
    end else if (grant_wr) begin
      starve_cnt_reg <= '0;
    end else if (grant_rd && wr_req && (starve_cnt_reg != STV_MAX)) begin
      starve_cnt_reg <= starve_cnt_reg + STV_W'(1);
    end
  end

  // Outstanding reads and sticky underflow flag for returns nobody asked for.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      if (app_rdata_valid && (outstanding_reg == '0)) begin
        err_reg <= 1'b1;
      end
      case ({rd_fire, app_rdata_valid})
        2'b10:   outstanding_reg <= outstanding_reg + OUT_W'(1);
        2'b01: begin
          if (outstanding_reg != '0) begin
            outstanding_reg <= outstanding_reg - OUT_W'(1);
          end
        end
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  // Read return path: one register stage, independent of the current burst.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data_valid_reg <= 1'b0;
      rd_data_reg       <= '0;
    end else begin
      rd_data_valid_reg <= app_rdata_valid;
      rd_data_reg       <= app_rdata;
    end
  end

  // Remember the last issued command so the bus holds steady between beats.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_cmd_reg  <= CMD_WRITE;
      last_addr_reg <= '0;
    end else if (beat_fire) begin
      last_cmd_reg  <= rd_fire ? CMD_READ : CMD_WRITE;
      last_addr_reg <= cur_addr_reg;
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter
// Directed stimulus with a burst-level reference model that is compared
// against the DUT outputs on every falling clock edge, plus literal checks of
// grant timing, grant order, address sequences and the read window limit.
module tb_ddr_port_arbiter;

  localparam int BL   = 16;
  localparam int STEP = 8;
  localparam int MAXO = 32;
  localparam int SL   = 4;

  logic         clk;
  logic         nrst;
  logic         init_calib_complete;
  logic         wr_req;
  logic [27:0]  wr_addr;
  logic         wr_gnt;
  logic [127:0] wr_data;
  logic         wr_data_valid;
  logic         wr_data_ready;
  logic         wr_done;
  logic         rd_req;
  logic [27:0]  rd_addr;
  logic         rd_gnt;
  logic         rd_done;
  logic [127:0] rd_data;
  logic         rd_data_valid;
  logic         app_cmd_en;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic         app_cmd_rdy;
  logic         app_wren;
  logic [127:0] app_data;
  logic         app_data_rdy;
  logic         app_rdata_valid;
  logic [127:0] app_rdata;
  logic         err_underflow;

  // read-data sources: automatic responder or manual pulses
  logic         rsp_en;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         man_valid;
  logic [127:0] man_data;
  int           rsp_done_cnt;
  int           man_cnt;

  assign app_rdata_valid = rsp_en ? rsp_valid : man_valid;
  assign app_rdata       = rsp_en ? rsp_data  : man_data;

  ddr_port_arbiter #(
    .BURST_LEN(BL), .ADDR_STEP(STEP), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .nrst(nrst), .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt), .wr_data(wr_data),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .app_cmd_en(app_cmd_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_cmd_rdy(app_cmd_rdy), .app_wren(app_wren), .app_data(app_data),
    .app_data_rdy(app_data_rdy), .app_rdata_valid(app_rdata_valid),
    .app_rdata(app_rdata), .err_underflow(err_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (burst level) ----------------
  int           m_mode;      // 0 calibrating, 1 idle, 2 writing, 3 reading
  int           m_left;      // beats still to go in the current burst
  logic [27:0]  m_addr;
  int           m_starve;
  int           m_out;
  bit           m_err, m_wgnt, m_rgnt, m_wdone, m_rdone, m_rv;
  logic [127:0] m_rd;
  logic [2:0]   m_lcmd;
  logic [27:0]  m_laddr;

  // observation records
  logic [27:0] wr_q[$];
  logic [27:0] rd_q[$];
  int cyc = 0, n_cmd = 0, n_gnt = 0, rd_cmd_seen = 0;
  int n_wr_done = 0, n_rd_done = 0, last_wren_cyc = 0, wr_done_cyc = 0;

  initial begin
    bit e_wf, e_rf, e_en;
    logic [2:0]  e_cmd;
    logic [27:0] e_addr;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        m_mode = 0; m_left = 0; m_addr = '0; m_starve = 0; m_out = 0;
        m_err = 0; m_wgnt = 0; m_rgnt = 0; m_wdone = 0; m_rdone = 0;
        m_rv = 0; m_rd = '0; m_lcmd = 3'b000; m_laddr = '0;
      end
      e_wf   = nrst && m_mode == 2 && app_cmd_rdy && app_data_rdy && wr_data_valid;
      e_rf   = nrst && m_mode == 3 && app_cmd_rdy && (m_out < MAXO);
      e_en   = e_wf || e_rf;
      e_cmd  = e_rf ? 3'b001 : (e_wf ? 3'b000 : m_lcmd);
      e_addr = e_en ? m_addr : m_laddr;
      chk("app_cmd_en", 128'(app_cmd_en), 128'(e_en));
      chk("app_wren", 128'(app_wren), 128'(e_wf));
      chk("wr_data_ready", 128'(wr_data_ready), 128'(e_wf));
      chk("app_cmd", 128'(app_cmd), 128'(e_cmd));
      chk("app_addr", 128'(app_addr), 128'(e_addr));
      chk("wr_gnt", 128'(wr_gnt), 128'(m_wgnt));
      chk("rd_gnt", 128'(rd_gnt), 128'(m_rgnt));
      chk("wr_done", 128'(wr_done), 128'(m_wdone));
      chk("rd_done", 128'(rd_done), 128'(m_rdone));
      chk("rd_data_valid", 128'(rd_data_valid), 128'(m_rv));
      chk("rd_data", rd_data, m_rd);
      chk("err_underflow", 128'(err_underflow), 128'(m_err));
      if (app_wren) chk("app_data", app_data, wr_data);

      if (nrst) begin
        if (e_en) begin
          m_lcmd  = e_rf ? 3'b001 : 3'b000;
          m_laddr = m_addr;
        end
        if (app_rdata_valid && m_out == 0) m_err = 1;
        if (e_rf && !app_rdata_valid) m_out++;
        else if (!e_rf && app_rdata_valid && m_out > 0) m_out--;
        m_rv = app_rdata_valid;
        m_rd = app_rdata;
        m_wgnt = 0; m_rgnt = 0; m_wdone = 0; m_rdone = 0;
        if (m_mode == 0) begin
          if (init_calib_complete) m_mode = 1;
        end else if (m_mode == 1) begin
          if (rd_req && !(wr_req && m_starve == SL)) begin
            m_mode = 3; m_addr = rd_addr; m_left = BL; m_rgnt = 1;
            if (wr_req && m_starve < SL) m_starve++;
          end else if (wr_req) begin
            m_mode = 2; m_addr = wr_addr; m_left = BL; m_wgnt = 1; m_starve = 0;
          end
        end else if (e_en) begin
          m_addr = 28'((int'(m_addr) + STEP) % (1 << 28));
          m_left--;
          if (m_left == 0) begin
            if (m_mode == 2) m_wdone = 1; else m_rdone = 1;
            m_mode = 1;
          end
        end
      end

      cyc++;
      if (app_cmd_en) n_cmd++;
      if (app_wren) begin
        wr_q.push_back(app_addr);
        last_wren_cyc = cyc;
      end
      if (app_cmd_en && app_cmd == 3'b001) begin
        rd_q.push_back(app_addr);
        rd_cmd_seen++;
      end
      if (wr_gnt) begin n_gnt++; $display("[%0t] grant WR base=%07h", $time, wr_addr); end
      if (rd_gnt) begin n_gnt++; $display("[%0t] grant RD base=%07h", $time, rd_addr); end
      if (wr_done) begin n_wr_done++; wr_done_cyc = cyc; $display("[%0t] done WR", $time); end
      if (rd_done) begin n_rd_done++; $display("[%0t] done RD", $time); end
    end
  end

  // automatic read responder: one return per cycle for every unanswered command
  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_done_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rsp_en && (rd_cmd_seen > rsp_done_cnt + man_cnt)) begin
        rsp_valid = 1'b1;
        rsp_data  = {32'h5A5A0000, 64'h0, 32'(rsp_done_cnt)};
        rsp_done_cnt++;
      end else begin
        rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input bit is_wr, input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = is_wr ? wr_gnt : rd_gnt;
    end
    chk(name, 128'(seen), 128'(1));
  endtask

  task automatic wait_done(input bit is_wr, input int target, input string name);
    for (int i = 0; i < 1000; i++) begin
      if ((is_wr ? n_wr_done : n_rd_done) >= target) break;
      tick();
    end
    chk(name, 128'((is_wr ? n_wr_done : n_rd_done) >= target), 128'(1));
  endtask

  initial begin
    int g0, c0, ng, base_w, base_r;
    bit order[10];
    bit exp_order[10];
    nrst = 0; init_calib_complete = 0;
    wr_req = 0; wr_addr = '0; wr_data = {32'hCAFE0000, 96'h1}; wr_data_valid = 1;
    rd_req = 0; rd_addr = '0; app_cmd_rdy = 1; app_data_rdy = 1;
    rsp_en = 0; man_valid = 0; man_data = '0; man_cnt = 0;

    // ---- 1: calibration gate and first write burst
    repeat (3) tick();
    chk("reset_wr_gnt", 128'(wr_gnt), 128'(0));
    chk("reset_cmd_en", 128'(app_cmd_en), 128'(0));
    nrst = 1; wr_req = 1; wr_addr = 28'h0000100;
    g0 = n_gnt; c0 = n_cmd;
    repeat (50) tick();
    chk("no_gnt_before_calib", 128'(n_gnt - g0), 128'(0));
    chk("no_cmd_before_calib", 128'(n_cmd - c0), 128'(0));
    init_calib_complete = 1;
    tick();
    chk("wr_gnt_calib_plus1", 128'(wr_gnt), 128'(0));
    tick();
    chk("wr_gnt_calib_plus2", 128'(wr_gnt), 128'(1));
    wr_req = 0;
    wait_done(1, 1, "wr_burst1_done");
    chk("wr_burst1_beats", 128'(wr_q.size()), 128'(BL));
    for (int i = 0; i < BL && i < wr_q.size(); i++)
      chk($sformatf("wr_addr_%0d", i), 128'(wr_q[i]), 128'(28'h100 + 8 * i));
    chk("wr_done_lag", 128'(wr_done_cyc - last_wren_cyc), 128'(1));

    // ---- 2: both requesters held, starvation limit forces a write
    rsp_en = 1;
    base_w = n_wr_done;
    rd_req = 1; wr_req = 1; rd_addr = 28'h0002000; wr_addr = 28'h0004000;
    ng = 0;
    for (int i = 0; i < 2000 && ng < 10; i++) begin
      tick();
      if (rd_gnt) begin order[ng] = 1; ng++; end
      else if (wr_gnt) begin order[ng] = 0; ng++; end
    end
    rd_req = 0; wr_req = 0;
    chk("grant_count", 128'(ng), 128'(10));
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++)
      chk($sformatf("grant_order_%0d", i), 128'(order[i]), 128'(exp_order[i]));
    wait_done(1, base_w + 2, "starve_wr_done");
    repeat (10) tick();

    // ---- 3: read window limit with no returns
    rsp_en = 0;
    base_r = n_rd_done;
    c0 = rd_cmd_seen;
    rd_req = 1; rd_addr = 28'h0008000;
    ng = 0;
    for (int i = 0; i < 300 && ng < 3; i++) begin
      tick();
      if (rd_gnt) ng++;
    end
    rd_req = 0;
    repeat (20) tick();
    chk("rd_cmds_at_limit", 128'(rd_cmd_seen - c0), 128'(32));
    man_data = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_0000_0042;
    man_valid = 1; man_cnt = 1;
    tick();
    man_valid = 0;
    chk("rd_ret_valid", 128'(rd_data_valid), 128'(1));
    chk("rd_ret_data", rd_data, 128'h0123_4567_89AB_CDEF_DEAD_BEEF_0000_0042);
    repeat (3) tick();
    chk("rd_cmds_after_one_ret", 128'(rd_cmd_seen - c0), 128'(33));
    rsp_en = 1;
    wait_done(0, base_r + 3, "rd_window_done");
    repeat (10) tick();

    // ---- 4: write with app_data_rdy toggling and wr_data_valid gaps
    wr_q.delete();
    base_w = n_wr_done;
    wr_req = 1; wr_addr = 28'h0ABCD00;
    wait_gnt(1, "wr_gnt_gappy");
    wr_req = 0;
    for (int k = 0; k < 400 && n_wr_done < base_w + 1; k++) begin
      app_data_rdy  = (k % 2 == 0);
      wr_data_valid = (k % 3 != 1);
      wr_data       = {32'hC0DE0000, 64'h0, 32'(k)};
      tick();
    end
    chk("gappy_done", 128'(n_wr_done), 128'(base_w + 1));
    app_data_rdy = 1; wr_data_valid = 1;
    chk("gappy_beats", 128'(wr_q.size()), 128'(BL));
    for (int i = 0; i < BL && i < wr_q.size(); i++)
      chk($sformatf("gappy_addr_%0d", i), 128'(wr_q[i]), 128'(28'h0ABCD00 + 8 * i));

    // ---- 5: address wrap and underflow flag
    rd_q.delete();
    base_r = n_rd_done;
    rd_req = 1; rd_addr = 28'hFFFFFF8;
    wait_gnt(0, "rd_gnt_wrap");
    rd_req = 0;
    wait_done(0, base_r + 1, "wrap_done");
    chk("wrap_addr_0", 128'(rd_q.size() > 0 ? rd_q[0] : 28'h1), 128'(28'hFFFFFF8));
    chk("wrap_addr_1", 128'(rd_q.size() > 1 ? rd_q[1] : 28'h1), 128'(28'h0000000));
    chk("wrap_addr_2", 128'(rd_q.size() > 2 ? rd_q[2] : 28'h1), 128'(28'h0000008));
    repeat (10) tick();
    rsp_en = 0;
    tick();
    chk("err_before_pulse", 128'(err_underflow), 128'(0));
    man_valid = 1; man_data = 128'h77;
    tick();
    man_valid = 0;
    chk("err_set", 128'(err_underflow), 128'(1));
    repeat (5) tick();
    chk("err_sticky", 128'(err_underflow), 128'(1));

    // ---- 6: reset in the middle of a write burst
    rsp_en = 1;
    wr_q.delete();
    wr_req = 1; wr_addr = 28'h0000300;
    wait_gnt(1, "wr_gnt_pre_reset");
    wr_req = 0;
    for (int i = 0; i < 100 && wr_q.size() < 5; i++) tick();
    chk("beats_before_reset", 128'(wr_q.size()), 128'(5));
    nrst = 0;
    #1;
    chk("rst_cmd_en", 128'(app_cmd_en), 128'(0));
    chk("rst_wren", 128'(app_wren), 128'(0));
    chk("rst_wr_ready", 128'(wr_data_ready), 128'(0));
    chk("rst_app_addr", 128'(app_addr), 128'(0));
    chk("rst_err", 128'(err_underflow), 128'(0));
    chk("rst_pulses", 128'({wr_gnt, rd_gnt, wr_done, rd_done, rd_data_valid}), 128'(0));
    repeat (2) tick();
    nrst = 1;
    base_r = n_rd_done;
    rd_req = 1; rd_addr = 28'h0000500;
    tick();
    chk("post_rst_no_gnt_yet", 128'(rd_gnt), 128'(0));
    tick();
    chk("post_rst_rd_gnt", 128'(rd_gnt), 128'(1));
    rd_req = 0;
    wait_done(0, base_r + 1, "post_rst_rd_done");
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single DDR3 controller user port between two requesters: the CSI capture path (write bursts) and the HDMI fetch path (read bursts).
- Sequences fixed-length bursts of 128-bit beats and gates all traffic until calibration completes.
- Reads have priority, with a starvation limit that guarantees write service.
- Returns read data in order and tracks outstanding reads.

Parameters:
- BURST_LEN, 16, beats (commands) per granted burst; 1..256.
- ADDR_STEP, 8, app_addr increment per beat (BL8 on x16 = 8 words).
- MAX_OUTSTANDING, 32, read commands issued but not yet returned; issue stalls at this value.
- STARVE_LIMIT, 4, consecutive read grants allowed while wr_req is pending; the next grant is then forced to write.

Ports:
- clk  in  1  controller user clock (clk_x1 domain).
- nrst  in  1  asynchronous active-low reset.
- init_calib_complete  in  1  DDR calibration done.
- wr_req  in  1  write burst request; held until wr_gnt.
- wr_addr  in  28  write burst base address; stable while wr_req=1.
- wr_gnt  out  1  one-cycle pulse: write burst accepted.
- wr_data  in  128  write beat.
- wr_data_valid  in  1  wr_data valid.
- wr_data_ready  out  1  beat consumed this cycle.
- wr_done  out  1  one-cycle pulse after the last write beat.
- rd_req  in  1  read burst request; held until rd_gnt.
- rd_addr  in  28  read burst base address.
- rd_gnt  out  1  one-cycle pulse: read burst accepted.
- rd_done  out  1  one-cycle pulse after the last read command is issued.
- rd_data  out  128  returned read beat.
- rd_data_valid  out  1  rd_data valid.
- app_cmd_en  out  1  command strobe to the controller.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_addr  out  28  command address.
- app_cmd_rdy  in  1  controller accepts a command.
- app_wren  out  1  write data strobe (also drives wr_data_end at top level).
- app_data  out  128  write data (= wr_data).
- app_data_rdy  in  1  controller accepts write data.
- app_rdata_valid  in  1  read data valid.
- app_rdata  in  128  read data.
- err_underflow  out  1  sticky: app_rdata_valid seen with zero outstanding.

Behaviour:
- Reset: all outputs 0; state INIT; beat_cnt, starve_cnt, outstanding = 0. Async assert, sync release. Reset mid-burst abandons the burst; the requester re-requests.
- States: INIT, IDLE, WR, RD (registered).
  - INIT -> IDLE when init_calib_complete=1. Calibration is sampled only in INIT; a later drop is ignored.
  - IDLE arbitration, per cycle:
    - force_wr = wr_req && starve_cnt==STARVE_LIMIT.
    - If rd_req && !force_wr -> RD, else if wr_req -> WR, else stay in IDLE.
    - On transition: latch base addr into cur_addr, beat_cnt=0.
    - wr_gnt/rd_gnt registered, high in the first cycle of WR/RD.
  - starve_cnt: +1 (saturating at STARVE_LIMIT) on each RD grant while wr_req=1; cleared on WR grant; unchanged on RD grant with wr_req=0.
  - WR beat fires when app_cmd_rdy && app_data_rdy && wr_data_valid (combinational).
    - Same cycle: app_cmd_en=1, app_wren=1, app_cmd=000, wr_data_ready=1, app_addr=cur_addr.
    - Else app_cmd_en=app_wren=wr_data_ready=0.
  - RD beat fires when app_cmd_rdy && outstanding<MAX_OUTSTANDING: app_cmd_en=1, app_cmd=001.
  - After each fired beat: cur_addr += ADDR_STEP (mod 2^28 wrap), beat_cnt+1.
  - The beat with beat_cnt==BURST_LEN-1 ends the burst -> IDLE next cycle, with wr_done/rd_done pulsed in that cycle (one cycle after the last beat). IDLE may re-grant in that same cycle (gnt follows one cycle later).
  - Minimum gap between bursts: 1 IDLE cycle.
- Outstanding counter:
  - +1 on a read command fire, -1 on app_rdata_valid; both in the same cycle -> unchanged.
  - app_rdata_valid with outstanding==0 -> counter stays 0, err_underflow set until reset.
- Read return path, registered 1 cycle: rd_data_valid<=app_rdata_valid, rd_data<=app_rdata, in order. Returns continue in any state, including during WR.
- Request withdrawn before grant: not an error; arbitration re-evaluates each IDLE cycle.
- app_cmd/app_addr hold their last values when app_cmd_en=0.

Test Plan:
- Reset, init_calib_complete=0 for 50 cycles with wr_req=1 -> no gnt, app_cmd_en=0. Raise calib -> wr_gnt at cycle+2, 16 write beats at 0x100, 0x108..0x178; wr_done 1 cycle after the last beat.
- wr_req and rd_req both held continuously, STARVE_LIMIT=4 -> grant order RD,RD,RD,RD,WR,RD,RD,RD,RD,WR.
- Read burst with app_rdata_valid held low -> exactly 32 read commands issued, then stall. One return -> one more command. rd_data is the app_rdata sequence delayed 1 cycle.
- Write burst with app_data_rdy toggling 1/0 and wr_data_valid gaps -> beats fire only when all three are high. Addresses are contiguous and app_wren==app_cmd_en every cycle.
- rd_addr=0xFFFFFF8, BURST_LEN=2 -> addresses 0xFFFFFF8, 0x0000000. Pulse app_rdata_valid with outstanding=0 -> err_underflow=1 and stays set.
- Deassert nrst mid-WR burst (beat 5) -> all outputs 0 immediately. After release, INIT; with calib=1 -> IDLE next cycle, outstanding=0.
